// File: rtl/mul_operand_issue.sv
// mul_operand_issue: FIFO-buffered operand feeder for the shift-and-add multiplier.
// Presents one (a, b) pair at a time and holds off the next until completion.
module mul_operand_issue #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [WIDTH-1:0] s_a,
   input  logic [WIDTH-1:0] s_b,
   output logic             mul_in_valid,
   input  logic             mul_in_ready,
   output logic [WIDTH-1:0] mul_a,
   output logic [WIDTH-1:0] mul_b,
   input  logic             mul_out_valid,
   output logic             inflight,
   output logic [CNT_W-1:0] fifo_count,
   output logic             err_spurious,
   output logic             err_ready_drop
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t           state;
   logic [WIDTH-1:0] mem_a [DEPTH];
   logic [WIDTH-1:0] mem_b [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next;
   logic             push;
   logic             pop;
   logic             ready_q;
   logic [WIDTH-1:0] head_a;
   logic [WIDTH-1:0] head_b;

   assign s_ready    = (count != CNT_W'(DEPTH));
   assign push       = s_valid && s_ready;
   assign pop        = mul_in_valid && mul_in_ready;
   assign fifo_count = count;
   assign count_next = count + CNT_W'(push) - CNT_W'(pop);

   // A pair enqueued on the completion cycle into an empty FIFO is forwarded
   // straight into the issue registers, so it is not yet in storage.
   assign head_a = (count == '0) ? s_a : mem_a[rd_ptr];
   assign head_b = (count == '0) ? s_b : mem_b[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) begin
         mem_a[wr_ptr] <= s_a;
         mem_b[wr_ptr] <= s_b;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         mul_in_valid   <= 1'b0;
         mul_a          <= '0;
         mul_b          <= '0;
         inflight       <= 1'b0;
         err_spurious   <= 1'b0;
         err_ready_drop <= 1'b0;
         ready_q        <= 1'b0;
      end else begin
         count   <= count_next;
         ready_q <= mul_in_ready;
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (mul_out_valid && !inflight) err_spurious <= 1'b1;
         case (state)
            IDLE: begin
               if (count != '0) begin
                  state        <= ISSUE;
                  mul_in_valid <= 1'b1;
                  mul_a        <= head_a;
                  mul_b        <= head_b;
               end
            end
            ISSUE: begin
               if (mul_in_ready) begin
                  state        <= WAIT;
                  mul_in_valid <= 1'b0;
                  inflight     <= 1'b1;
               end else if (ready_q) begin
                  err_ready_drop <= 1'b1;
               end
            end
            WAIT: begin
               if (mul_out_valid) begin
                  inflight <= 1'b0;
                  if (count_next != '0) begin
                     state        <= ISSUE;
                     mul_in_valid <= 1'b1;
                     mul_a        <= head_a;
                     mul_b        <= head_b;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mul_operand_issue.sv
// Bench for mul_operand_issue: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_mul_operand_issue;
   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int CNT_W = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             s_valid = 1'b0;
   logic             s_ready;
   logic [WIDTH-1:0] s_a = '0;
   logic [WIDTH-1:0] s_b = '0;
   logic             mul_in_valid;
   logic             mul_in_ready = 1'b0;
   logic [WIDTH-1:0] mul_a;
   logic [WIDTH-1:0] mul_b;
   logic             mul_out_valid = 1'b0;
   logic             inflight;
   logic [CNT_W-1:0] fifo_count;
   logic             err_spurious;
   logic             err_ready_drop;

   int tests = 0;
   int fails = 0;
   bit model_on = 1'b0;

   // reference model state
   logic [2*WIDTH-1:0] m_q[$];
   bit                 m_pres, m_infl, m_esp, m_erd, m_prev_rdy;
   logic [WIDTH-1:0]   m_a, m_b;

   typedef struct {
      logic             sv;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             rdy;
      logic             ov;
      logic             e_valid;
      logic [WIDTH-1:0] e_a;
      logic [WIDTH-1:0] e_b;
      logic             e_infl;
      logic [CNT_W-1:0] e_cnt;
   } vec_t;

   vec_t tbl[16];

   always #5 clk = ~clk;

   mul_operand_issue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
      .mul_in_valid(mul_in_valid), .mul_in_ready(mul_in_ready), .mul_a(mul_a), .mul_b(mul_b),
      .mul_out_valid(mul_out_valid), .inflight(inflight), .fifo_count(fifo_count),
      .err_spurious(err_spurious), .err_ready_drop(err_ready_drop)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_pres = 0; m_infl = 0; m_esp = 0; m_erd = 0; m_prev_rdy = 0;
      m_a = '0; m_b = '0;
   endtask

   // One clock of behaviour, computed from the inputs present before the edge.
   task automatic model_step();
      bit pop_m, push_m;
      int pre_size;
      pre_size = m_q.size();
      pop_m  = m_pres && mul_in_ready;
      push_m = s_valid && (pre_size != DEPTH);
      if (mul_out_valid && !m_infl) m_esp = 1;
      if (m_pres && m_prev_rdy && !mul_in_ready) m_erd = 1;
      if (pop_m) void'(m_q.pop_front());
      if (push_m) m_q.push_back({s_a, s_b});
      if (m_pres) begin
         if (mul_in_ready) begin
            m_pres = 0;
            m_infl = 1;
         end
      end else if (m_infl) begin
         if (mul_out_valid) begin
            m_infl = 0;
            if (m_q.size() != 0) begin
               m_pres = 1;
               {m_a, m_b} = m_q[0];
            end
         end
      end else if (pre_size != 0) begin
         m_pres = 1;
         {m_a, m_b} = m_q[0];
      end
      m_prev_rdy = mul_in_ready;
   endtask

   task automatic model_check();
      logic [31:0] act, exp;
      act = {8'h0, mul_in_valid, mul_a, mul_b, inflight, fifo_count, s_ready,
             err_spurious, err_ready_drop};
      exp = {8'h0, m_pres, m_a, m_b, m_infl, CNT_W'(m_q.size()), m_q.size() != DEPTH,
             m_esp, m_erd};
      check("random_cycle", act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      if (model_on) model_step();
      @(negedge clk);
      if (model_on) model_check();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      s_valid = 0; s_a = '0; s_b = '0; mul_in_ready = 0; mul_out_valid = 0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   // Waits (bounded) for an issue, checks the operands, lets it be accepted and completes it.
   task automatic issue_and_complete(input string name, input logic [WIDTH-1:0] ea,
                                     input logic [WIDTH-1:0] eb);
      int n;
      n = 0;
      while (!mul_in_valid && n < 20) begin
         step();
         n++;
      end
      check({name, "_valid"}, mul_in_valid, 1);
      check({name, "_a"}, mul_a, ea);
      check({name, "_b"}, mul_b, eb);
      mul_in_ready = 1;
      step();
      check({name, "_inflight"}, inflight, 1);
      mul_out_valid = 1;
      step();
      mul_out_valid = 0;
   endtask

   initial begin
      //          sv  a      b      rdy ov   valid e_a    e_b    infl cnt
      tbl[0]  = '{1, 8'h05, 8'h03, 1, 0,   0, 8'h00, 8'h00, 0, 3'd1};
      tbl[1]  = '{0, 8'h00, 8'h00, 1, 0,   1, 8'h05, 8'h03, 0, 3'd1};
      tbl[2]  = '{0, 8'h00, 8'h00, 1, 0,   0, 8'h05, 8'h03, 1, 3'd0};
      tbl[3]  = '{1, 8'h00, 8'hFF, 0, 0,   0, 8'h05, 8'h03, 1, 3'd1};
      tbl[4]  = '{1, 8'h12, 8'h34, 0, 1,   1, 8'h00, 8'hFF, 0, 3'd2};
      tbl[5]  = '{0, 8'h00, 8'h00, 1, 0,   0, 8'h00, 8'hFF, 1, 3'd1};
      tbl[6]  = '{0, 8'h00, 8'h00, 0, 1,   1, 8'h12, 8'h34, 0, 3'd1};
      tbl[7]  = '{0, 8'h00, 8'h00, 1, 0,   0, 8'h12, 8'h34, 1, 3'd0};
      tbl[8]  = '{0, 8'h00, 8'h00, 1, 1,   0, 8'h12, 8'h34, 0, 3'd0};
      tbl[9]  = '{0, 8'h00, 8'h00, 1, 0,   0, 8'h12, 8'h34, 0, 3'd0};
      tbl[10] = '{1, 8'hA1, 8'hB2, 1, 0,   0, 8'h12, 8'h34, 0, 3'd1};
      tbl[11] = '{0, 8'h00, 8'h00, 1, 0,   1, 8'hA1, 8'hB2, 0, 3'd1};
      tbl[12] = '{0, 8'h00, 8'h00, 1, 0,   0, 8'hA1, 8'hB2, 1, 3'd0};
      tbl[13] = '{1, 8'hC3, 8'hD4, 0, 1,   1, 8'hC3, 8'hD4, 0, 3'd1};
      tbl[14] = '{0, 8'h00, 8'h00, 1, 0,   0, 8'hC3, 8'hD4, 1, 3'd0};
      tbl[15] = '{0, 8'h00, 8'h00, 1, 1,   0, 8'hC3, 8'hD4, 0, 3'd0};

      // reset state
      do_reset();
      check("rst_count", fifo_count, 0);
      check("rst_s_ready", s_ready, 1);
      check("rst_valid", mul_in_valid, 0);
      check("rst_ab", {mul_a, mul_b}, 0);
      check("rst_inflight", inflight, 0);
      check("rst_errs", {err_spurious, err_ready_drop}, 0);

      // vector table: single op, completion with pending entry, forward on empty
      for (int i = 0; i < 16; i++) begin
         s_valid = tbl[i].sv; s_a = tbl[i].a; s_b = tbl[i].b;
         mul_in_ready = tbl[i].rdy; mul_out_valid = tbl[i].ov;
         step();
         check($sformatf("vec%0d", i),
               {mul_in_valid, mul_a, mul_b, inflight, fifo_count, s_ready, err_spurious, err_ready_drop},
               {tbl[i].e_valid, tbl[i].e_a, tbl[i].e_b, tbl[i].e_infl, tbl[i].e_cnt,
                tbl[i].e_cnt != CNT_W'(DEPTH), 2'b00});
      end
      s_valid = 0; mul_in_ready = 0; mul_out_valid = 0;

      // fill and stall: fifth pair refused
      do_reset();
      for (int k = 0; k < 5; k++) begin
         s_valid = 1; s_a = 8'((k + 1) * 17); s_b = 8'(k + 1);
         step();
      end
      s_valid = 0;
      check("fill_count", fifo_count, 4);
      check("fill_s_ready", s_ready, 0);
      check("fill_head_a", mul_a, 8'h11);
      for (int k = 0; k < 4; k++)
         issue_and_complete($sformatf("fill%0d", k), 8'((k + 1) * 17), 8'(k + 1));
      step();
      check("fill_drained", {mul_in_valid, fifo_count}, 0);
      check("fill_errs", {err_spurious, err_ready_drop}, 0);

      // simultaneous enqueue and dequeue at count 2
      do_reset();
      s_valid = 1; s_a = 8'h21; s_b = 8'h01; step();
      s_a = 8'h22; s_b = 8'h02; step();
      s_a = 8'h23; s_b = 8'h03; mul_in_ready = 1; step();
      s_valid = 0; mul_in_ready = 0;
      check("same_cycle_count", fifo_count, 2);
      mul_out_valid = 1; step(); mul_out_valid = 0;
      issue_and_complete("order1", 8'h22, 8'h02);
      issue_and_complete("order2", 8'h23, 8'h03);

      // ready drop during ISSUE
      do_reset();
      mul_in_ready = 1; s_valid = 1; s_a = 8'h5A; s_b = 8'hA5; step();
      s_valid = 0; step();
      mul_in_ready = 0; step();
      check("drop_err", err_ready_drop, 1);
      check("drop_hold", {mul_in_valid, mul_a, mul_b}, {1'b1, 8'h5A, 8'hA5});
      step();
      check("drop_sticky", {err_ready_drop, mul_a, mul_b}, {1'b1, 8'h5A, 8'hA5});
      mul_in_ready = 1; step();
      check("drop_after_accept", {err_ready_drop, inflight}, 2'b11);

      // asynchronous reset while waiting with three queued pairs
      do_reset();
      mul_in_ready = 1; s_valid = 1; s_a = 8'h01; s_b = 8'h01; step();
      s_valid = 0; step();
      step();
      mul_in_ready = 0; s_valid = 1;
      for (int k = 0; k < 3; k++) begin
         s_a = 8'(k + 2); step();
      end
      s_valid = 0;
      check("pre_rst_state", {inflight, fifo_count}, {1'b1, 3'd3});
      #2 rst = 1'b1;
      #1;
      check("async_rst", {fifo_count, inflight, mul_in_valid, s_ready}, {3'd0, 1'b0, 1'b0, 1'b1});
      @(negedge clk);
      rst = 1'b0;
      mul_out_valid = 1; step(); mul_out_valid = 0;
      check("spurious_after_rst", err_spurious, 1);
      step();
      check("spurious_sticky", {err_spurious, mul_in_valid}, 2'b10);

      // randomized run against the reference model
      do_reset();
      model_on = 1;
      for (int c = 0; c < 3000 && fails < 40; c++) begin
         s_valid = 1'($urandom_range(0, 1));
         s_a = 8'($urandom);
         s_b = 8'($urandom);
         if ($urandom_range(0, 7) == 0) s_a = '0;
         if ($urandom_range(0, 7) == 0) s_b = '0;
         mul_in_ready = ($urandom_range(0, 9) < 7);
         mul_out_valid = m_infl && ($urandom_range(0, 2) == 0);
         step();
      end
      model_on = 0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/mul_operand_issue.md
Name: mul_operand_issue

Overview:
- Upstream feeder for the shift-and-add multiplier.
- Buffers (a, b) operand pairs from a producer in a small FIFO and presents one pair at a time to the multiplier's in_valid/in_ready interface.
- Holds off the next issue until the multiplier reports completion (out_valid), so at most one operation is in flight.
- Flags protocol errors: a completion with nothing in flight, or in_ready dropping while an issue is pending.

Parameters:
- WIDTH, 8, operand width in bits (matches multiplier operand width).
- DEPTH, 4, FIFO entries; power of two, at least 2.
- CNT_W, $clog2(DEPTH)+1, width of occupancy count.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- s_valid  input  1  producer offers an operand pair.
- s_ready  output  1  FIFO can accept; equals (count != DEPTH).
- s_a  input  WIDTH  operand a.
- s_b  input  WIDTH  operand b.
- mul_in_valid  output  1  issue request to the multiplier.
- mul_in_ready  input  1  multiplier idle (its !busy).
- mul_a  output  WIDTH  operand a to the multiplier; valid while mul_in_valid.
- mul_b  output  WIDTH  operand b to the multiplier; valid while mul_in_valid.
- mul_out_valid  input  1  multiplier completion (its finish/out_valid).
- inflight  output  1  an issued operation has not yet completed.
- fifo_count  output  CNT_W  current FIFO occupancy.
- err_spurious  output  1  sticky: mul_out_valid seen while not inflight.
- err_ready_drop  output  1  sticky: mul_in_ready fell while in ISSUE.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - FIFO empty; fifo_count=0; s_ready=1.
  - mul_in_valid=0; mul_a=0; mul_b=0.
  - inflight=0; both error flags=0; FSM=IDLE.
- Reset mid-operation discards all FIFO entries and the in-flight state. A later completion pulse from the multiplier then sets err_spurious. This is intended and documents the lost operation.
- Enqueue: when s_valid && s_ready, {s_a, s_b} is written at the tail.
- Dequeue: happens only on an issue handshake (mul_in_valid && mul_in_ready).
- Simultaneous enqueue and dequeue:
  - Both proceed in the same cycle and fifo_count is unchanged.
  - When full (s_ready=0), enqueue is refused even if a dequeue occurs that cycle. s_ready has no combinational path from mul_in_ready.
- Pointers wrap modulo DEPTH. fifo_count never exceeds DEPTH and never goes below 0.
- FSM:
  - IDLE: FIFO non-empty -> go to ISSUE next cycle.
  - ISSUE:
    - mul_in_valid=1; mul_a/mul_b are the registered FIFO head.
    - On mul_in_valid && mul_in_ready: pop the head, set inflight=1, go to WAIT next cycle.
    - If mul_in_ready is low, stay in ISSUE.
    - If mul_in_ready was high last cycle and is low now while still in ISSUE, set err_ready_drop.
  - WAIT:
    - mul_in_valid=0; mul_a/mul_b hold their last issued values.
    - On mul_out_valid: clear inflight. Go to ISSUE if the FIFO is non-empty after that cycle's enqueue, else go to IDLE.
- Issue latency:
  - A pair written into an empty FIFO at edge N raises mul_in_valid after edge N+1.
  - With mul_in_ready=1 it is accepted at edge N+2.
- Back-to-back issue: the earliest next mul_in_valid is the cycle after mul_out_valid is seen. No operand is ever presented while inflight=1.
- mul_out_valid in IDLE or ISSUE (inflight=0) sets err_spurious and is otherwise ignored. Error flags clear only on rst.
- mul_a and mul_b are stable for the whole time mul_in_valid=1, including stalls.
- Operand value is irrelevant to control flow: zero operands are issued like any other pair.

Test Plan:
- Reset behaviour: assert rst asynchronously mid-cycle while in WAIT with fifo_count=3 -> immediately fifo_count=0, inflight=0, mul_in_valid=0, s_ready=1. Then pulse mul_out_valid -> err_spurious=1.
- Single operation: push (a=5, b=3) into an empty block with mul_in_ready=1 -> mul_in_valid high 1 cycle later with mul_a=5, mul_b=3. Accepted next edge; inflight=1 until a mul_out_valid pulse, then inflight=0 and FSM returns to IDLE.
- Fill and stall: with mul_in_ready=0, push 5 pairs (0x11/0x01 .. 0x55/0x05) -> first 4 accepted, s_ready=0, fifo_count=4, 5th refused. Release mul_in_ready -> pairs issue in FIFO order, one per completion.
- Same-cycle enqueue and dequeue at count=2 -> count stays 2; ordering is preserved across pointer wrap over 10 operations.
- Completion with a pending entry: mul_out_valid arrives while the FIFO holds (0, 0xFF) -> next cycle ISSUE with mul_a=0, mul_b=0xFF, no bubble beyond 1 cycle.
- Protocol errors: drop mul_in_ready for 1 cycle during ISSUE after it was high -> err_ready_drop=1, held sticky, and mul_a/mul_b unchanged throughout.
